// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture core: state encoding, trigger
// modes and the per-bit trigger evaluation helper.
package la_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    READ  = 3'd5
  } la_state_e;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  // Unmasked bits always agree, so an all-zero mask forces a trigger.
  function automatic logic trig_bit_match(input logic cur, input logic prev, input logic val,
                                          input logic edge_mode, input logic mask);
    if (!mask) return 1'b1;
    if (edge_mode == TRIG_EDGE) return (cur != prev) && (cur == val);
    return cur == val;
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port synchronous sample buffer: one write port, one registered
// read port with read enable (output holds while re_i is low).
module la_sample_ram #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular pre/post-trigger buffer with masked
// level/edge trigger and valid/ready readout. Optional LA_STORAGE_QUALIFIER_EN adds cap_en_i.
module la_capture_core
  import la_pkg::*;
#(
  parameter int   DATA_W = 36,
  parameter int   DEPTH  = 1024,
  parameter int   TRIG_W = 4,
  localparam int  ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [TRIG_W-1:0]  trig_i,
  input  logic [TRIG_W-1:0]  trig_mask_i,
  input  logic [TRIG_W-1:0]  trig_value_i,
  input  logic [TRIG_W-1:0]  trig_edge_i,
  input  logic [ADDR_W-1:0]  pretrig_i,
  input  logic               arm_i,
  input  logic               abort_i,
`ifdef LA_STORAGE_QUALIFIER_EN
  input  logic               cap_en_i,
`endif
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_last_o,
  output logic [STATE_W-1:0] state_o,
  output logic [ADDR_W-1:0]  trig_addr_o
);

  // Readout handshake: a sample moves when rd_valid_o && rd_ready_i at a clock
  // edge; while rd_valid_o is high and rd_ready_i low, data and last are held.

  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  la_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d, cnt_q, cnt_d, pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d, ra_q, ra_d, ld_q, ld_d;
  logic [ADDR_W:0]   iss_q, iss_d;
  logic [TRIG_W-1:0] prev_q;
  logic              pend_q, pend_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_rdata;
  logic              cap_en, trig_hit, we, re, load;

`ifdef LA_STORAGE_QUALIFIER_EN
  assign cap_en = cap_en_i;
`else
  assign cap_en = 1'b1;
`endif

  always_comb begin
    trig_hit = 1'b1;
    for (int i = 0; i < TRIG_W; i++) begin
      trig_hit = trig_hit & trig_bit_match(trig_i[i], prev_q[i], trig_value_i[i],
                                           trig_edge_i[i], trig_mask_i[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    cnt_d       = cnt_q;
    pretrig_d   = pretrig_q;
    trig_addr_d = trig_addr_q;
    ra_d        = ra_q;
    iss_d       = iss_q;
    ld_d        = ld_q;
    pend_d      = pend_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    we          = 1'b0;
    re          = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // pretrig_i is ADDR_W wide, so it can never exceed DEPTH-1.
        if (arm_i) begin
          wp_d      = '0;
          cnt_d     = '0;
          pretrig_d = pretrig_i;
          state_d   = (pretrig_i == '0) ? ARMED : FILL;
        end
      end
      FILL: begin
        if (cap_en) begin
          we    = 1'b1;
          wp_d  = wp_q + ONE;
          cnt_d = cnt_q + ONE;
          if (cnt_q + ONE == pretrig_q) state_d = ARMED;
        end
      end
      ARMED: begin
        if (cap_en) begin
          we   = 1'b1;
          wp_d = wp_q + ONE;
          if (trig_hit) begin
            trig_addr_d = wp_q;
            cnt_d       = LAST_ADDR - pretrig_q;
            state_d     = (pretrig_q == LAST_ADDR) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (cap_en) begin
          we    = 1'b1;
          wp_d  = wp_q + ONE;
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) state_d = DONE;
        end
      end
      DONE: begin
        ra_d    = trig_addr_q - pretrig_q;
        iss_d   = '0;
        ld_d    = '0;
        pend_d  = 1'b0;
        state_d = READ;
      end
      READ: begin
        // pend_q marks a RAM word fetched but not yet moved to the output stage.
        load   = pend_q && (!rd_valid_q || rd_ready_i);
        re     = (iss_q != DEPTH_CNT) && (!pend_q || load);
        pend_d = re || (pend_q && !load);
        if (re) begin
          ra_d  = ra_q + ONE;
          iss_d = iss_q + (ADDR_W + 1)'(1);
        end
        if (load) begin
          rd_valid_d = 1'b1;
          rd_data_d  = ram_rdata;
          rd_last_d  = (ld_q == LAST_ADDR);
          ld_d       = ld_q + ONE;
        end else if (rd_valid_q && rd_ready_i) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
        if (rd_valid_q && rd_ready_i && rd_last_q) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d    = IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      pend_d     = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      cnt_q       <= '0;
      pretrig_q   <= '0;
      trig_addr_q <= '0;
      ra_q        <= '0;
      iss_q       <= '0;
      ld_q        <= '0;
      prev_q      <= '0;
      pend_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
      pretrig_q   <= pretrig_d;
      trig_addr_q <= trig_addr_d;
      ra_q        <= ra_d;
      iss_q       <= iss_d;
      ld_q        <= ld_d;
      prev_q      <= trig_i;
      pend_q      <= pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  la_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wp_q),
    .wdata_i (data_i),
    .re_i    (re),
    .raddr_i (ra_q),
    .rdata_o (ram_rdata)
  );

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign state_o     = state_q;
  assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core (DEPTH=16, DATA_W=8): directed T1-T7 plus random
// captures checked against a write-list reference model.
module tb_la_capture_core;
  import la_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TRIG_W = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [TRIG_W-1:0] trig = '0, trig_mask = '0, trig_value = '0, trig_edge = '0;
  logic [ADDR_W-1:0] pretrig = '0;
  logic              arm = 1'b0, abort_s = 1'b0, rd_ready = 1'b0, cap_en = 1'b1;
  logic              rd_valid_o, rd_last_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [2:0]        state_o;
  logic [ADDR_W-1:0] trig_addr_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [TRIG_W-1:0] prev_m = '0;
  logic [DATA_W-1:0] wr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_arr [DEPTH];
  logic [ADDR_W-1:0] obs_taddr;

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TRIG_W(TRIG_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .trig_i       (trig),
    .trig_mask_i  (trig_mask),
    .trig_value_i (trig_value),
    .trig_edge_i  (trig_edge),
    .pretrig_i    (pretrig),
    .arm_i        (arm),
    .abort_i      (abort_s),
`ifdef LA_STORAGE_QUALIFIER_EN
    .cap_en_i     (cap_en),
`endif
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o),
    .state_o      (state_o),
    .trig_addr_o  (trig_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Clock/reset helper: advance one edge, record what the trigger history saw.
  task automatic step();
    @(posedge clk);
    prev_m = rst ? '0 : trig;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic bit model_match(input logic [3:0] t, input logic [3:0] p, input logic [3:0] m,
                                     input logic [3:0] v, input logic [3:0] e);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (t[i] != v[i]) return 1'b0;
        if (e[i] && (t[i] == p[i])) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] trig_at(input int mode, input int cnt);
    case (mode)
      1:       return (cnt == 20) ? 4'b0001 : 4'b0000;
      2:       return (cnt < 8 || cnt >= 9) ? 4'b0010 : 4'b0000;
      3:       return (cnt == 3 || cnt == 12) ? 4'b0001 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  // Driver + model: data counts from 0 on the first cycle after arm; the model keeps
  // the list of written samples and locates the trigger among them.
  task automatic capture(input string tag, input int pt, input logic [3:0] m, input logic [3:0] v,
                         input logic [3:0] e, input int mode, input int stall_at,
                         input int abort_at, input bit rst_in_post, input bit qual);
    int n_wr, trig_k, got, stall_n;
    bit done, last, hold, r;
    logic [DATA_W-1:0] hold_d;
    logic hold_l;
    logic [3:0] t;
    la_state_e phase;
    trig_mask = m; trig_value = v; trig_edge = e; pretrig = ADDR_W'(pt);
    rd_ready = 1'b0;
    trig = (mode == 0) ? 4'($urandom_range(0, 15)) : trig_at(mode, -1);
    arm = 1'b1;
    step();
    arm = 1'b0;
    wr_q.delete(); exp_q.delete();
    n_wr = 0; trig_k = -1; done = 1'b0;
    for (int cnt = 0; cnt < 400 && !done; cnt++) begin
      if (mode == 0) t = (cnt >= 72) ? (cnt[1] ? v : ~v) : 4'($urandom_range(0, 15));
      else t = trig_at(mode, cnt);
      cap_en = qual ? (cnt % 2 == 0) : 1'b1;
      data = DATA_W'(cnt);
      trig = t;
      phase = (n_wr < pt) ? FILL : ((trig_k < 0) ? ARMED : POST);
      check({tag, " capture state"}, 32'(state_o), 32'(phase));
      if (rst_in_post && phase == POST) begin
        #2 rst = 1'b1;
        #1;
        check({tag, " rst state"}, 32'(state_o), 32'(IDLE));
        check({tag, " rst valid"}, 32'(rd_valid_o), 0);
        check({tag, " rst data"}, 32'(rd_data_o), 0);
        check({tag, " rst last"}, 32'(rd_last_o), 0);
        check({tag, " rst trig_addr"}, 32'(trig_addr_o), 0);
        step(); step();
        #2 rst = 1'b0;
        return;
      end
      last = 1'b0;
      if (cap_en) begin
        wr_q.push_back(DATA_W'(cnt));
        if (phase == ARMED && model_match(t, prev_m, m, v, e)) trig_k = n_wr;
        n_wr++;
        last = (trig_k >= 0) && (n_wr == trig_k + DEPTH - pt);
      end
      step();
      done = last;
    end
    cap_en = 1'b1;
    if (!done) begin
      bound_fail({tag, " capture end"});
      return;
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(wr_q[trig_k - pt + i]);
    check({tag, " done state"}, 32'(state_o), 32'(DONE));
    check({tag, " trig_addr"}, 32'(trig_addr_o), 32'(trig_k % DEPTH));
    obs_taddr = trig_addr_o;
    step();
    check({tag, " read state"}, 32'(state_o), 32'(READ));
    check({tag, " valid at read+0"}, 32'(rd_valid_o), 0);
    step();
    check({tag, " valid at read+1"}, 32'(rd_valid_o), 0);
    step();
    check({tag, " valid at read+2"}, 32'(rd_valid_o), 1);
    // Scoreboard: transfers are compared in order against exp_q.
    got = 0; stall_n = 0; hold = 1'b0; hold_d = '0; hold_l = 1'b0;
    for (int cyc = 0; cyc < 400 && got < DEPTH; cyc++) begin
      if (abort_at >= 0 && got == abort_at) begin
        abort_s = 1'b1; rd_ready = 1'b0;
        step();
        abort_s = 1'b0;
        check({tag, " abort valid"}, 32'(rd_valid_o), 0);
        check({tag, " abort state"}, 32'(state_o), 32'(IDLE));
        return;
      end
      if (hold) begin
        check({tag, " hold valid"}, 32'(rd_valid_o), 1);
        check({tag, " hold data"}, 32'(rd_data_o), 32'(hold_d));
        check({tag, " hold last"}, 32'(rd_last_o), 32'(hold_l));
      end
      if (stall_at >= 0) begin
        r = !(got >= stall_at && stall_n < 5);
        if (!r && rd_valid_o) stall_n++;
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      rd_ready = r;
      if (rd_valid_o && r) begin
        check({tag, " rd_data"}, 32'(rd_data_o), 32'(exp_q[got]));
        check({tag, " rd_last"}, 32'(rd_last_o), 32'(got == DEPTH - 1));
        got_arr[got] = rd_data_o;
        got++;
      end
      hold = rd_valid_o && !r;
      hold_d = rd_data_o;
      hold_l = rd_last_o;
      step();
    end
    rd_ready = 1'b0;
    if (got < DEPTH) begin
      bound_fail({tag, " readout"});
      return;
    end
    check({tag, " end state"}, 32'(state_o), 32'(IDLE));
    check({tag, " end valid"}, 32'(rd_valid_o), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset state", 32'(state_o), 32'(IDLE));
    check("reset valid", 32'(rd_valid_o), 0);
    check("reset data", 32'(rd_data_o), 0);
    check("reset last", 32'(rd_last_o), 0);
    check("reset trig_addr", 32'(trig_addr_o), 0);
    step(); step();
    #2 rst = 1'b0;
    step();

    capture("t1", 4, 4'b0001, 4'b0001, 4'b0000, 1, -1, -1, 1'b0, 1'b0);
    check("t1 first sample", 32'(got_arr[0]), 16);
    check("t1 trigger sample", 32'(got_arr[4]), 20);

    capture("t2", 0, 4'b0000, 4'b0000, 4'b0000, 1, -1, -1, 1'b0, 1'b0);
    check("t2 trig_addr", 32'(obs_taddr), 0);
    check("t2 first sample", 32'(got_arr[0]), 0);

    capture("t3", 7, 4'b0010, 4'b0010, 4'b0010, 2, -1, -1, 1'b0, 1'b0);
    check("t3 trigger sample", 32'(got_arr[7]), 9);

    capture("t4", 8, 4'b0001, 4'b0001, 4'b0000, 3, -1, -1, 1'b0, 1'b0);
    check("t4 trigger sample", 32'(got_arr[8]), 12);

    capture("t5", 4, 4'b0001, 4'b0001, 4'b0000, 1, 6, 10, 1'b0, 1'b0);

    arm = 1'b1; abort_s = 1'b1;
    step();
    arm = 1'b0; abort_s = 1'b0;
    check("abort beats arm", 32'(state_o), 32'(IDLE));

    capture("t6", 4, 4'b0001, 4'b0001, 4'b0000, 1, -1, -1, 1'b1, 1'b0);
    step();
    capture("t6 rearm", 4, 4'b0001, 4'b0001, 4'b0000, 1, -1, -1, 1'b0, 1'b0);
    check("t6 rearm trigger sample", 32'(got_arr[4]), 20);

`ifdef LA_STORAGE_QUALIFIER_EN
    capture("t7", 4, 4'b0001, 4'b0001, 4'b0000, 1, -1, -1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) check("t7 even sample", 32'(got_arr[i][0]), 0);
    check("t7 trigger sample", 32'(got_arr[4]), 20);
`endif

    for (int n = 0; n < 6; n++) begin
      capture("rand", int'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, -1, -1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
